// File: rtl/gps_gen_pkg.sv
// Shared definitions for the GPS generator run controller: register map,
// CTRL bit positions, sequencer FSM states and the configuration structs
// exchanged between the register bank and the sequencer top.
package gps_gen_pkg;

  // Register map
  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_SAT      = 3'd1;
  localparam logic [2:0] ADDR_CA_PHASE = 3'd2;
  localparam logic [2:0] ADDR_DOPPLER  = 3'd3;
  localparam logic [2:0] ADDR_SNR      = 3'd4;
  localparam logic [2:0] ADDR_MSG_LO   = 3'd5;
  localparam logic [2:0] ADDR_MSG_HI   = 3'd6;
  localparam logic [2:0] ADDR_SWEEP    = 3'd7;

  // CTRL bit indices
  localparam int unsigned CTRL_RUN        = 0;
  localparam int unsigned CTRL_NOISE_OFF  = 1;
  localparam int unsigned CTRL_SIGNAL_OFF = 2;
  localparam int unsigned CTRL_SWEEP_EN   = 3;
  localparam int unsigned CTRL_MSG_EN     = 4;

  // C/A code length (1023 chips) at the core's 4x oversampling
  localparam int unsigned GC_OVERSAMPLED_LENGTH = 1023 * 4;

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  // Fields that drive the core directly
  typedef struct packed {
    logic        msg_en;
    logic        signal_off;
    logic        noise_off;
    logic [4:0]  sat;
    logic [15:0] ca_phase;
    logic [7:0]  snr;
    logic [31:0] msg;
  } core_cfg_t;

  // Fields consumed by the Doppler sweep
  typedef struct packed {
    logic       sweep_en;
    logic [7:0] step;
    logic [7:0] start;
    logic [7:0] dmax;
    logic [7:0] dwell;
  } sweep_cfg_t;

  typedef struct packed {
    core_cfg_t  core;
    sweep_cfg_t sweep;
  } cfg_t;

  function automatic cfg_t cfg_reset(input logic [31:0] msg_preset);
    cfg_t c;
    c          = '0;
    c.core.msg = msg_preset;
    return c;
  endfunction

endpackage

// File: rtl/gps_cfg_regfile.sv
// Shadow/active configuration register bank.
//  clk_i, rst_i     clock, synchronous active-high reset
//  wr_en_i          accepted write this cycle
//  wr_addr_i/data_i write address / data
//  busy_i           sequencer not idle: writes are held in shadow until commit
//  commit_i         epoch boundary while busy: shadow -> active
//  core_o           active core-facing fields (registered)
//  sweep_next_o     sweep fields as they will be after this cycle's write/commit
module gps_cfg_regfile
  import gps_gen_pkg::*;
#(
  parameter int unsigned NB_DATA    = 16,
  parameter int unsigned NB_ADDR    = 3,
  parameter logic [31:0] MSG_PRESET = 32'hFEEDCAFE
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [NB_ADDR-1:0] wr_addr_i,
  input  logic [NB_DATA-1:0] wr_data_i,
  input  logic               busy_i,
  input  logic               commit_i,
  output core_cfg_t          core_o,
  output sweep_cfg_t         sweep_next_o
);

  cfg_t shadow_q, shadow_d;
  cfg_t active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i) begin
      unique case (wr_addr_i)
        ADDR_CTRL: begin
          // run bit is owned by the sequencer FSM
          shadow_d.core.msg_en     = wr_data_i[CTRL_MSG_EN];
          shadow_d.sweep.sweep_en  = wr_data_i[CTRL_SWEEP_EN];
          shadow_d.core.signal_off = wr_data_i[CTRL_SIGNAL_OFF];
          shadow_d.core.noise_off  = wr_data_i[CTRL_NOISE_OFF];
        end
        ADDR_SAT:      shadow_d.core.sat      = wr_data_i[4:0];
        ADDR_CA_PHASE: shadow_d.core.ca_phase = wr_data_i[15:0];
        ADDR_DOPPLER: begin
          shadow_d.sweep.step  = wr_data_i[15:8];
          shadow_d.sweep.start = wr_data_i[7:0];
        end
        ADDR_SNR:      shadow_d.core.snr        = wr_data_i[7:0];
        ADDR_MSG_LO:   shadow_d.core.msg[15:0]  = wr_data_i[15:0];
        ADDR_MSG_HI:   shadow_d.core.msg[31:16] = wr_data_i[15:0];
        ADDR_SWEEP: begin
          shadow_d.sweep.dmax  = wr_data_i[15:8];
          shadow_d.sweep.dwell = wr_data_i[7:0];
        end
      endcase
    end

    // Idle: writes go straight through. Busy: only epoch commits move shadow
    // to active; writes are stalled during commit cycles so shadow_q is final.
    active_d = active_q;
    if (!busy_i) begin
      active_d = shadow_d;
    end else if (commit_i) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= cfg_reset(MSG_PRESET);
      active_q <= cfg_reset(MSG_PRESET);
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign core_o       = active_q.core;
  assign sweep_next_o = active_d.sweep;

endmodule

// File: rtl/gps_gen_sequencer.sv
// Run controller for gps_gen_core.
//  clk_in, rst_in        clock, synchronous active-high reset
//  cfg_valid_in/addr/data config write request; cfg_ready_out accepts it
//  epoch_in              1-cycle pulse at C/A code wrap from the core
//  ena_out .. signal_off_out  configuration driven into the core
//  busy_out              sequencer not idle
//  bit_edge_out          1-cycle pulse when the nav bit index advances
module gps_gen_sequencer
  import gps_gen_pkg::*;
#(
  parameter int unsigned NB_DATA        = 16,
  parameter int unsigned NB_ADDR        = 3,
  parameter int unsigned EPOCHS_PER_BIT = 20,
  parameter logic [31:0] MSG_PRESET     = 32'hFEEDCAFE
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               cfg_valid_in,
  input  logic [NB_ADDR-1:0] cfg_addr_in,
  input  logic [NB_DATA-1:0] cfg_data_in,
  output logic               cfg_ready_out,
  input  logic               epoch_in,
  output logic               ena_out,
  output logic               msg_out,
  output logic [4:0]         n_sat_out,
  output logic [15:0]        ca_phase_out,
  output logic [7:0]         doppler_out,
  output logic [7:0]         snr_out,
  output logic               noise_off_out,
  output logic               signal_off_out,
  output logic               busy_out,
  output logic               bit_edge_out
);

  localparam int unsigned EpochW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
  localparam logic [EpochW-1:0] EpochLast = EpochW'(EPOCHS_PER_BIT - 1);

  state_e            state_q, state_d;
  logic [EpochW-1:0] epoch_cnt_q, epoch_cnt_d;
  logic [4:0]        bit_idx_q, bit_idx_d;
  logic              bit_edge_q, bit_edge_d;
  logic [7:0]        doppler_q, doppler_d;
  logic [7:0]        dwell_cnt_q, dwell_cnt_d;

  logic       busy, wr_en, ctrl_wr, run_bit, go, epoch_busy;
  logic [8:0] sum;
  core_cfg_t  core;
  sweep_cfg_t sweep_next;

  assign busy          = (state_q != StIdle);
  // Stall writes on commit cycles so a write never races a commit
  assign cfg_ready_out = ~(epoch_in & busy);
  assign wr_en         = cfg_valid_in & cfg_ready_out;
  assign ctrl_wr       = wr_en & (cfg_addr_in == ADDR_CTRL);
  assign run_bit       = cfg_data_in[CTRL_RUN];
  assign go            = (state_q == StIdle) & ctrl_wr & run_bit;
  assign epoch_busy    = epoch_in & busy;

  gps_cfg_regfile #(
    .NB_DATA   (NB_DATA),
    .NB_ADDR   (NB_ADDR),
    .MSG_PRESET(MSG_PRESET)
  ) u_regfile (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .wr_en_i     (wr_en),
    .wr_addr_i   (cfg_addr_in),
    .wr_data_i   (cfg_data_in),
    .busy_i      (busy),
    .commit_i    (epoch_busy),
    .core_o      (core),
    .sweep_next_o(sweep_next)
  );

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (ctrl_wr && run_bit) state_d = StRun;
      StRun:      if (ctrl_wr && !run_bit) state_d = StStopping;
      StStopping: begin
        if (epoch_in) begin
          state_d = StIdle;
        end else if (ctrl_wr && run_bit) begin
          state_d = StRun;
        end
      end
      default:    state_d = StIdle;
    endcase
  end

  // Nav-message epoch / bit counters
  always_comb begin
    epoch_cnt_d = epoch_cnt_q;
    bit_idx_d   = bit_idx_q;
    bit_edge_d  = 1'b0;
    if (go) begin
      epoch_cnt_d = '0;
      bit_idx_d   = '0;
    end else if (epoch_busy) begin
      if (epoch_cnt_q == EpochLast) begin
        epoch_cnt_d = '0;
        bit_idx_d   = bit_idx_q + 5'd1;
        bit_edge_d  = 1'b1;
      end else begin
        epoch_cnt_d = epoch_cnt_q + EpochW'(1);
      end
    end
  end

  // Doppler sweep; uses post-commit values so a same-epoch commit applies first
  always_comb begin
    sum         = {1'b0, doppler_q} + {1'b0, sweep_next.step};
    doppler_d   = doppler_q;
    dwell_cnt_d = dwell_cnt_q;
    if (!busy || !sweep_next.sweep_en) begin
      doppler_d   = sweep_next.start;
      dwell_cnt_d = '0;
    end else if (epoch_in) begin
      if (dwell_cnt_q == sweep_next.dwell) begin
        dwell_cnt_d = '0;
        // Covers both 8-bit overflow (sum[8]) and exceeding dmax
        doppler_d   = (sum > {1'b0, sweep_next.dmax}) ? sweep_next.start : sum[7:0];
      end else begin
        dwell_cnt_d = dwell_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      epoch_cnt_q <= '0;
      bit_idx_q   <= '0;
      bit_edge_q  <= 1'b0;
      doppler_q   <= '0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      epoch_cnt_q <= epoch_cnt_d;
      bit_idx_q   <= bit_idx_d;
      bit_edge_q  <= bit_edge_d;
      doppler_q   <= doppler_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign busy_out       = busy;
  assign ena_out        = busy;
  assign bit_edge_out   = bit_edge_q;
  assign msg_out        = core.msg_en & core.msg[5'd31 - bit_idx_q];
  assign n_sat_out      = core.sat;
  assign ca_phase_out   = core.ca_phase;
  assign doppler_out    = doppler_q;
  assign snr_out        = core.snr;
  assign noise_off_out  = core.noise_off;
  assign signal_off_out = core.signal_off;

endmodule
